// File: rtl/bird_motion.sv
// Flappy Bird motion block: frame-tick gravity/flap integrator with an IDLE/FLY/DEAD game FSM.
// Optional macro BIRD_FRAC_EN adds 4 fractional bits to position and velocity (1/16-pixel units).
module bird_motion #(
  parameter int unsigned SCREEN_H = 480,
  parameter int unsigned BIRD_X   = 160,
  parameter int unsigned BIRD_S   = 6,
  parameter int unsigned Y_START  = 240,
  parameter int unsigned GRAVITY  = 1,
  parameter int unsigned FLAP_VEL = 7,
  parameter int unsigned MAX_FALL = 8,
  parameter logic [7:0]  FLAP_KEY = 8'h2C,
  parameter int unsigned POS_W    = 10,
  parameter int unsigned VEL_W    = 6
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             frame_clk,
  input  logic [7:0]       keycode,
  input  logic             Hit,
  output logic [POS_W-1:0] BirdX,
  output logic [POS_W-1:0] BirdY,
  output logic [POS_W-1:0] BirdS,
  output logic [VEL_W-1:0] Vel,
  output logic             Alive,
  output logic             Dead,
  output logic             Flap
);

`ifdef BIRD_FRAC_EN
  localparam int unsigned FW = 4;
`else
  localparam int unsigned FW = 0;
`endif

  localparam int unsigned PW = POS_W + FW;
  localparam int unsigned VW = VEL_W + FW;
  localparam int unsigned AW = PW + 1;

  localparam logic [PW-1:0]        Y_START_FX = PW'(Y_START << FW);
  localparam logic signed [VW-1:0] FLAP_V     = VW'(0 - FLAP_VEL);
  localparam logic signed [VW-1:0] GRAV_V     = VW'(GRAVITY);
  localparam logic signed [VW-1:0] MAX_V      = VW'(MAX_FALL);
  localparam logic signed [AW-1:0] CEIL_A     = AW'(BIRD_S << FW);
  localparam logic signed [AW-1:0] GROUND_A   = AW'((SCREEN_H - 1 - BIRD_S) << FW);

  typedef enum logic [1:0] {S_IDLE, S_FLY, S_DEAD} state_e;

  state_e                state_q, state_d;
  logic [2:0]            fs_q, fs_d;
  logic                  tick_q, tick_d;
  logic                  key_hit_q;
  logic                  pend_q, pend_d;
  logic [PW-1:0]         y_q, y_d;
  logic signed [VW-1:0]  v_q, v_d;
  logic                  alive_q, alive_d;
  logic                  dead_q, dead_d;
  logic                  flap_q, flap_d;

  logic                  key_hit, press, do_flap;
  logic signed [VW:0]    v_inc;
  logic signed [VW-1:0]  v_new;
  logic signed [AW-1:0]  y_new;
  logic                  hit_ceil, hit_ground;

  // Two-flop synchroniser on VS plus rising-edge detect, registered into a 1-cycle tick.
  assign fs_d    = {fs_q[1:0], frame_clk};
  assign tick_d  = fs_q[1] & ~fs_q[2];
  assign key_hit = (keycode == FLAP_KEY);
  assign press   = key_hit & ~key_hit_q;

  // Candidate integration step; a same-cycle press counts as a pending flap.
  always_comb begin
    do_flap    = pend_q | press;
    v_inc      = (VW+1)'(v_q) + (VW+1)'(GRAV_V);
    v_new      = (v_inc > (VW+1)'(MAX_V)) ? MAX_V : VW'(v_inc);
    if (do_flap) v_new = FLAP_V;
    y_new      = $signed({1'b0, y_q}) + AW'(v_new);
    hit_ceil   = (y_new < CEIL_A);
    hit_ground = (y_new >= GROUND_A);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (press) state_d = S_FLY;
      S_FLY: begin
        if (Hit)                           state_d = S_DEAD;
        else if (tick_q && !hit_ceil && hit_ground) state_d = S_DEAD;
      end
      S_DEAD: if (press) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    y_d     = y_q;
    v_d     = v_q;
    pend_d  = pend_q;
    flap_d  = 1'b0;
    alive_d = (state_d == S_FLY);
    dead_d  = (state_d == S_DEAD);
    case (state_q)
      S_IDLE: begin
        y_d    = Y_START_FX;
        v_d    = '0;
        pend_d = press;
      end
      S_FLY: begin
        if (Hit) begin
          pend_d = 1'b0;
        end else if (tick_q) begin
          pend_d = 1'b0;
          flap_d = do_flap;
          if (hit_ceil) begin
            y_d = PW'(CEIL_A);
            v_d = '0;
          end else if (hit_ground) begin
            y_d = PW'(GROUND_A);
            v_d = '0;
          end else begin
            y_d = PW'(y_new);
            v_d = v_new;
          end
        end else if (press) begin
          pend_d = 1'b1;
        end
      end
      S_DEAD: begin
        pend_d = 1'b0;
        if (press) begin
          y_d = Y_START_FX;
          v_d = '0;
        end
      end
      default: pend_d = 1'b0;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fs_q      <= '0;
      tick_q    <= 1'b0;
      key_hit_q <= 1'b0;
      pend_q    <= 1'b0;
      y_q       <= Y_START_FX;
      v_q       <= '0;
      alive_q   <= 1'b0;
      dead_q    <= 1'b0;
      flap_q    <= 1'b0;
    end else begin
      fs_q      <= fs_d;
      tick_q    <= tick_d;
      key_hit_q <= key_hit;
      pend_q    <= pend_d;
      y_q       <= y_d;
      v_q       <= v_d;
      alive_q   <= alive_d;
      dead_q    <= dead_d;
      flap_q    <= flap_d;
    end
  end

  // Outputs are the integer parts; arithmetic shift floors negative velocities.
  assign BirdX = POS_W'(BIRD_X);
  assign BirdS = POS_W'(BIRD_S);
  assign BirdY = POS_W'(y_q >> FW);
  assign Vel   = VEL_W'(v_q >>> FW);
  assign Alive = alive_q;
  assign Dead  = dead_q;
  assign Flap  = flap_q;

endmodule
